// File: rtl/bp_stream_gate.sv
// bp_stream_gate: turns the controller's bp level into a registered s_rdy drop in front of a 2-entry skid buffer;
// saturating stall/packet statistics exist only when BP_STREAM_GATE_STAT_EN is defined.
module bp_stream_gate #(
    parameter int    DATA_WIDTH     = 512,
    parameter string BP_PKT_MODE    = "NO",
    parameter int    STAT_CNT_WIDTH = 32
) (
    input  logic                      clks,
    input  logic                      reset,
    input  logic                      ctrl_bp_en,
    input  logic [DATA_WIDTH-1:0]     s_data,
    input  logic                      s_sop,
    input  logic                      s_eop,
    input  logic                      s_vld,
    output logic                      s_rdy,
    output logic [DATA_WIDTH-1:0]     m_data,
    output logic                      m_sop,
    output logic                      m_eop,
    output logic                      m_vld,
    input  logic                      m_rdy,
    input  logic                      stat_clr,
    output logic [STAT_CNT_WIDTH-1:0] stat_stall_cnt,
    output logic [STAT_CNT_WIDTH-1:0] stat_pkt_cnt
);
    localparam int EW = DATA_WIDTH + 2;
    localparam bit PKT_MODE = (BP_PKT_MODE == "YES");
    logic [1:0]    occ_q, occ_d;
    logic [EW-1:0] head_q, head_d, skid_q, skid_d, in_word;
    logic          in_pkt_q, in_pkt_d, s_rdy_q, s_rdy_d, acc, emit, gate_next;
    assign in_word = {s_sop, s_eop, s_data};
    assign acc = s_vld & s_rdy_q;
    assign emit = m_vld & m_rdy;
    assign m_vld = occ_q != 2'd0;
    assign {m_sop, m_eop, m_data} = head_q;
    assign s_rdy = s_rdy_q;

    // buffer bookkeeping; ready is only granted when a word can land without overflowing
    always_comb begin
        occ_d = (acc & ~emit) ? occ_q + 2'd1 : (~acc & emit) ? occ_q - 2'd1 : occ_q;
        head_d = emit ? ((occ_q == 2'd2) ? skid_q : acc ? in_word : head_q)
                      : (acc && occ_q == 2'd0) ? in_word : head_q;
        skid_d = (acc && !emit && occ_q == 2'd1) ? in_word : skid_q;
        in_pkt_d = acc ? (s_eop ? 1'b0 : s_sop ? 1'b1 : in_pkt_q) : in_pkt_q;
        gate_next = ctrl_bp_en & ~(PKT_MODE & in_pkt_d);
        s_rdy_d = (occ_d < 2'd2) & ~gate_next;
    end

    // datapath and control state, cleared immediately on reset
    always_ff @(posedge clks or posedge reset) begin
        if (reset) begin
            occ_q <= 2'd0;
            head_q <= '0;
            skid_q <= '0;
            in_pkt_q <= 1'b0;
            s_rdy_q <= 1'b0;
        end else begin
            occ_q <= occ_d;
            head_q <= head_d;
            skid_q <= skid_d;
            in_pkt_q <= in_pkt_d;
            s_rdy_q <= s_rdy_d;
        end
    end

`ifdef BP_STREAM_GATE_STAT_EN
    localparam logic [STAT_CNT_WIDTH-1:0] CNT_ONE = 1;
    logic [STAT_CNT_WIDTH-1:0] stall_q, stall_d, pkt_q, pkt_d;

    // saturating counters; a clear beats a same-cycle increment
    always_comb begin
        stall_d = stat_clr ? '0 : (s_vld & ~s_rdy_q & ~&stall_q) ? stall_q + CNT_ONE : stall_q;
        pkt_d = stat_clr ? '0 : (emit & m_eop & ~&pkt_q) ? pkt_q + CNT_ONE : pkt_q;
    end

    // statistics registers
    always_ff @(posedge clks or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
            pkt_q <= '0;
        end else begin
            stall_q <= stall_d;
            pkt_q <= pkt_d;
        end
    end

    assign stat_stall_cnt = stall_q;
    assign stat_pkt_cnt = pkt_q;
`else
    logic unused_stat_clr;
    assign unused_stat_clr = stat_clr;
    assign stat_stall_cnt = '0;
    assign stat_pkt_cnt = '0;
`endif
endmodule

// File: tb/tb_bp_stream_gate.sv
// tb_bp_stream_gate: directed checks of word/packet gating, skid buffering, statistics and async reset
module tb_bp_stream_gate;
    localparam int DW = 16;
`ifdef BP_STREAM_GATE_STAT_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif
    logic clks = 1'b0, reset = 1'b0, ctrl_bp_en = 1'b0, s_sop = 1'b0, s_eop = 1'b0;
    logic s_vld = 1'b0, m_rdy = 1'b0, stat_clr = 1'b0, sel = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic n_s_rdy, n_m_sop, n_m_eop, n_m_vld, y_s_rdy, y_m_sop, y_m_eop, y_m_vld;
    logic [DW-1:0] n_m_data, y_m_data, md;
    logic [3:0] n_stall, n_pkt;
    logic [31:0] y_stall, y_pkt;
    logic rdy, mv, ms, me;
    logic [DW+1:0] exp_q[$], got_q[$];
    logic [DW-1:0] seq = 16'h0100;
    int errors = 0, checks = 0, acc_n = 0, low_n = 0, wi = 0, plen = 4;
    bit acc_last;

    always #5 clks = ~clks;

    bp_stream_gate #(.DATA_WIDTH(DW), .BP_PKT_MODE("NO"), .STAT_CNT_WIDTH(4)) u_no (
        .clks(clks), .reset(reset), .ctrl_bp_en(ctrl_bp_en), .s_data(s_data), .s_sop(s_sop),
        .s_eop(s_eop), .s_vld(s_vld), .s_rdy(n_s_rdy), .m_data(n_m_data), .m_sop(n_m_sop),
        .m_eop(n_m_eop), .m_vld(n_m_vld), .m_rdy(m_rdy), .stat_clr(stat_clr),
        .stat_stall_cnt(n_stall), .stat_pkt_cnt(n_pkt));

    bp_stream_gate #(.DATA_WIDTH(DW), .BP_PKT_MODE("YES"), .STAT_CNT_WIDTH(32)) u_yes (
        .clks(clks), .reset(reset), .ctrl_bp_en(ctrl_bp_en), .s_data(s_data), .s_sop(s_sop),
        .s_eop(s_eop), .s_vld(s_vld), .s_rdy(y_s_rdy), .m_data(y_m_data), .m_sop(y_m_sop),
        .m_eop(y_m_eop), .m_vld(y_m_vld), .m_rdy(m_rdy), .stat_clr(stat_clr),
        .stat_stall_cnt(y_stall), .stat_pkt_cnt(y_pkt));

    assign rdy = sel ? y_s_rdy : n_s_rdy;
    assign mv = sel ? y_m_vld : n_m_vld;
    assign ms = sel ? y_m_sop : n_m_sop;
    assign me = sel ? y_m_eop : n_m_eop;
    assign md = sel ? y_m_data : n_m_data;

    task automatic drive();
        s_data = seq;
        s_sop = (wi == 0);
        s_eop = (wi == plen - 1);
    endtask

    task automatic cycle();
        @(negedge clks);
        acc_last = s_vld & rdy;
        if (acc_last) begin
            exp_q.push_back({s_sop, s_eop, s_data});
            acc_n++;
        end
        if (mv & m_rdy) got_q.push_back({ms, me, md});
        if (!rdy) low_n++;
        @(posedge clks);
        #1;
        if (acc_last) begin
            seq++;
            wi = (wi == plen - 1) ? 0 : wi + 1;
        end
        drive();
    endtask

    task automatic restart();
        exp_q.delete();
        got_q.delete();
        acc_n = 0;
        low_n = 0;
        wi = 0;
        drive();
    endtask

    task automatic do_reset();
        s_vld = 1'b0;
        ctrl_bp_en = 1'b0;
        stat_clr = 1'b0;
        reset = 1'b1;
        @(negedge clks);
        reset = 1'b0;
        @(posedge clks);
        #1;
        restart();
    endtask

    task automatic drain();
        s_vld = 1'b0;
        ctrl_bp_en = 1'b0;
        m_rdy = 1'b1;
        repeat (4) cycle();
    endtask

    function automatic int seq_mismatch();
        int bad = (got_q.size() > exp_q.size()) ? got_q.size() - exp_q.size() : exp_q.size() - got_q.size();
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) bad++;
        return bad;
    endfunction

    task automatic test_reset();
        #1 reset = 1'b1;
        #10;
        checks++; if (n_s_rdy !== 1'b0) begin errors++; $display("FAIL reset_s_rdy: got %b expected 0", n_s_rdy); end
        checks++; if (n_m_vld !== 1'b0) begin errors++; $display("FAIL reset_m_vld: got %b expected 0", n_m_vld); end
        checks++; if ({n_m_sop, n_m_eop, n_m_data} !== '0) begin errors++; $display("FAIL reset_m_word: got %h expected 0", {n_m_sop, n_m_eop, n_m_data}); end
        checks++; if ({n_stall, n_pkt} !== 8'd0) begin errors++; $display("FAIL reset_stats: got %h expected 0", {n_stall, n_pkt}); end
        checks++; if (y_s_rdy !== 1'b0 || y_m_vld !== 1'b0) begin errors++; $display("FAIL reset_yes: got rdy=%b vld=%b expected 0/0", y_s_rdy, y_m_vld); end
        @(negedge clks);
        reset = 1'b0;
        @(posedge clks);
        #1;
        checks++; if (n_s_rdy !== 1'b1 || y_s_rdy !== 1'b1) begin errors++; $display("FAIL release_rdy: got %b/%b expected 1/1", n_s_rdy, y_s_rdy); end
    endtask

    task automatic test_passthrough();
        logic [DW-1:0] first;
        int cyc;
        do_reset();
        sel = 1'b0;
        plen = 4;
        restart();
        m_rdy = 1'b1;
        s_vld = 1'b1;
        first = seq;
        cycle();
        cyc = 1;
        checks++; if (n_m_vld !== 1'b1 || n_m_data !== first) begin errors++; $display("FAIL pass_latency: got vld=%b data=%h expected 1/%h", n_m_vld, n_m_data, first); end
        for (int i = 0; i < 200 && acc_n < 100; i++) begin
            cycle();
            cyc++;
        end
        s_vld = 1'b0;
        checks++; if (cyc !== 100 || acc_n !== 100) begin errors++; $display("FAIL pass_throughput: got %0d words in %0d cycles expected 100/100", acc_n, cyc); end
        checks++; if (low_n !== 0) begin errors++; $display("FAIL pass_rdy_low: got %0d cycles expected 0", low_n); end
        drain();
        checks++; if (seq_mismatch() !== 0) begin errors++; $display("FAIL pass_order: got %0d mismatches (%0d out) expected 0", seq_mismatch(), got_q.size()); end
        checks++; if (n_stall !== 4'd0) begin errors++; $display("FAIL pass_stall: got %0d expected 0", n_stall); end
        checks++; if (n_pkt !== (STAT ? 4'd15 : 4'd0)) begin errors++; $display("FAIL pass_pkt_sat: got %0d expected %0d", n_pkt, STAT ? 15 : 0); end
    endtask

    task automatic test_word_gate();
        do_reset();
        sel = 1'b0;
        plen = 8;
        restart();
        m_rdy = 1'b1;
        s_vld = 1'b1;
        repeat (3) cycle();
        ctrl_bp_en = 1'b1;
        repeat (10) cycle();
        ctrl_bp_en = 1'b0;
        repeat (6) cycle();
        checks++; if (low_n !== 10) begin errors++; $display("FAIL gate_low_cycles: got %0d expected 10", low_n); end
        checks++; if (acc_n !== 9) begin errors++; $display("FAIL gate_accepts: got %0d expected 9", acc_n); end
        checks++; if (n_stall !== (STAT ? 4'd10 : 4'd0)) begin errors++; $display("FAIL gate_stall_cnt: got %0d expected %0d", n_stall, STAT ? 10 : 0); end
        drain();
        checks++; if (seq_mismatch() !== 0) begin errors++; $display("FAIL gate_order: got %0d mismatches expected 0", seq_mismatch()); end
        checks++; if (n_pkt !== (STAT ? 4'd1 : 4'd0)) begin errors++; $display("FAIL gate_pkt_cnt: got %0d expected %0d", n_pkt, STAT ? 1 : 0); end
    endtask

    task automatic test_packet_gate();
        do_reset();
        sel = 1'b1;
        plen = 8;
        restart();
        m_rdy = 1'b1;
        s_vld = 1'b1;
        cycle();
        ctrl_bp_en = 1'b1;
        repeat (7) cycle();
        checks++; if (acc_n !== 8 || low_n !== 0) begin errors++; $display("FAIL pkt_finish: got acc=%0d low=%0d expected 8/0", acc_n, low_n); end
        checks++; if (y_s_rdy !== 1'b0) begin errors++; $display("FAIL pkt_rdy_after_eop: got %b expected 0", y_s_rdy); end
        repeat (5) cycle();
        checks++; if (acc_n !== 8 || y_s_rdy !== 1'b0) begin errors++; $display("FAIL pkt_hold: got acc=%0d rdy=%b expected 8/0", acc_n, y_s_rdy); end
        ctrl_bp_en = 1'b0;
        cycle();
        checks++; if (y_s_rdy !== 1'b1 || acc_n !== 8) begin errors++; $display("FAIL pkt_release: got rdy=%b acc=%0d expected 1/8", y_s_rdy, acc_n); end
        for (int i = 0; i < 40 && acc_n < 16; i++) cycle();
        s_vld = 1'b0;
        checks++; if (acc_n !== 16) begin errors++; $display("FAIL pkt_second: got %0d words expected 16", acc_n); end
        ctrl_bp_en = 1'b1;
        cycle();
        checks++; if (y_s_rdy !== 1'b0) begin errors++; $display("FAIL pkt_idle_gate: got %b expected 0", y_s_rdy); end
        drain();
        checks++; if (seq_mismatch() !== 0) begin errors++; $display("FAIL pkt_order: got %0d mismatches expected 0", seq_mismatch()); end
        checks++; if (y_stall !== (STAT ? 32'd6 : 32'd0) || y_pkt !== (STAT ? 32'd2 : 32'd0)) begin errors++; $display("FAIL pkt_stats: got stall=%0d pkt=%0d expected %0d/%0d", y_stall, y_pkt, STAT ? 6 : 0, STAT ? 2 : 0); end
    endtask

    task automatic test_skid_fill();
        do_reset();
        sel = 1'b0;
        plen = 4;
        restart();
        m_rdy = 1'b0;
        s_vld = 1'b1;
        repeat (3) cycle();
        checks++; if (acc_n !== 2 || n_s_rdy !== 1'b0 || n_m_vld !== 1'b1) begin errors++; $display("FAIL skid_full: got acc=%0d rdy=%b vld=%b expected 2/0/1", acc_n, n_s_rdy, n_m_vld); end
        checks++; if (n_m_data !== exp_q[0][DW-1:0]) begin errors++; $display("FAIL skid_head: got %h expected %h", n_m_data, exp_q[0][DW-1:0]); end
        m_rdy = 1'b1;
        s_vld = 1'b0;
        cycle();
        checks++; if (n_s_rdy !== 1'b1) begin errors++; $display("FAIL skid_recover: got %b expected 1", n_s_rdy); end
        drain();
        checks++; if (seq_mismatch() !== 0 || got_q.size() !== 2) begin errors++; $display("FAIL skid_order: got %0d words %0d mismatches expected 2/0", got_q.size(), seq_mismatch()); end
        for (int s = 0; s < 2; s++) begin
            do_reset();
            sel = s[0];
            plen = 3;
            restart();
            for (int i = 0; i < (s == 0 ? 10000 : 2000); i++) begin
                m_rdy = $urandom_range(0, 1) == 1;
                s_vld = $urandom_range(0, 3) != 0;
                if ($urandom_range(0, 7) == 0) ctrl_bp_en = ~ctrl_bp_en;
                cycle();
            end
            drain();
            checks++; if (seq_mismatch() !== 0 || acc_n < 100) begin errors++; $display("FAIL random_sb mode=%0d: got %0d mismatches over %0d words expected 0", s, seq_mismatch(), acc_n); end
        end
    endtask

    task automatic test_stat_sat_clr();
        do_reset();
        sel = 1'b0;
        ctrl_bp_en = 1'b1;
        cycle();
        s_vld = 1'b1;
        repeat (20) cycle();
        checks++; if (n_stall !== (STAT ? 4'd15 : 4'd0)) begin errors++; $display("FAIL stat_saturate: got %0d expected %0d", n_stall, STAT ? 15 : 0); end
        stat_clr = 1'b1;
        cycle();
        stat_clr = 1'b0;
        checks++; if (n_stall !== 4'd0) begin errors++; $display("FAIL stat_clear_prio: got %0d expected 0", n_stall); end
        cycle();
        checks++; if (n_stall !== (STAT ? 4'd1 : 4'd0)) begin errors++; $display("FAIL stat_after_clear: got %0d expected %0d", n_stall, STAT ? 1 : 0); end
        drain();
    endtask

    task automatic test_reset_mid();
        do_reset();
        sel = 1'b1;
        plen = 8;
        restart();
        m_rdy = 1'b0;
        s_vld = 1'b1;
        repeat (3) cycle();
        checks++; if (acc_n !== 2 || y_m_vld !== 1'b1 || y_s_rdy !== 1'b0) begin errors++; $display("FAIL mid_setup: got acc=%0d vld=%b rdy=%b expected 2/1/0", acc_n, y_m_vld, y_s_rdy); end
        reset = 1'b1;
        s_vld = 1'b0;
        #2;
        checks++; if (y_m_vld !== 1'b0 || y_s_rdy !== 1'b0 || y_m_data !== '0) begin errors++; $display("FAIL mid_async: got vld=%b rdy=%b data=%h expected 0/0/0", y_m_vld, y_s_rdy, y_m_data); end
        @(negedge clks);
        reset = 1'b0;
        @(posedge clks);
        #1;
        restart();
        checks++; if (y_s_rdy !== 1'b1 || y_stall !== 32'd0) begin errors++; $display("FAIL mid_release: got rdy=%b stall=%0d expected 1/0", y_s_rdy, y_stall); end
        ctrl_bp_en = 1'b1;
        cycle();
        checks++; if (y_s_rdy !== 1'b0) begin errors++; $display("FAIL mid_in_pkt_cleared: got %b expected 0", y_s_rdy); end
        ctrl_bp_en = 1'b0;
        cycle();
        m_rdy = 1'b1;
        s_vld = 1'b1;
        for (int i = 0; i < 30 && acc_n < 8; i++) cycle();
        s_vld = 1'b0;
        drain();
        checks++; if (seq_mismatch() !== 0 || got_q.size() !== 8) begin errors++; $display("FAIL mid_resume: got %0d words %0d mismatches expected 8/0", got_q.size(), seq_mismatch()); end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_passthrough();
        test_word_gate();
        test_packet_gate();
        test_skid_fill();
        test_stat_sat_clr();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
